// File: rtl/vj_pkg.sv
// Shared definitions for the detection path: frame geometry, pyramid widths,
// per-level upscale factors and the box record carried through the FIFO.
package vj_pkg;

    localparam int LAPTOP_WIDTH   = 320;
    localparam int LAPTOP_HEIGHT  = 240;
    localparam int PYRAMID_LEVELS = 6;
    localparam int PYRAMID_WIDTHS [PYRAMID_LEVELS] = '{320, 256, 213, 160, 128, 80};
    localparam int SCALE_FRAC     = 8;
    localparam int BOX_W          = 10;

    // Rounded fixed-point ratio of full frame width to the level width.
    function automatic int scale_for(input int level, input int frac);
        int w;
        if (level == 0) return 1 << frac;
        if (level >= PYRAMID_LEVELS) return 0;
        w = PYRAMID_WIDTHS[level];
        return ((1 << frac) * LAPTOP_WIDTH + w / 2) / w;
    endfunction

    localparam int SCALE_Q [PYRAMID_LEVELS] = '{
        scale_for(0, SCALE_FRAC), scale_for(1, SCALE_FRAC), scale_for(2, SCALE_FRAC),
        scale_for(3, SCALE_FRAC), scale_for(4, SCALE_FRAC), scale_for(5, SCALE_FRAC)
    };

    typedef struct packed {
        logic [BOX_W-1:0] x;
        logic [BOX_W-1:0] y;
        logic [BOX_W-1:0] size;
    } det_box_t;

endpackage

// File: rtl/detection_upscaler_box_fifo.sv
// Synchronous FIFO of det_box_t with registered count, valid flag and head,
// so the consumer sees outputs straight from flops.
module box_fifo
    import vj_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_en,
    input  det_box_t                   wr_data,
    input  logic                       rd_en,
    output logic                       rd_valid,
    output det_box_t                   rd_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    det_box_t             mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     rd_next;
    logic [CNT_W-1:0]     count_next;
    logic [CNT_W-1:0]     occ_after_pop;
    logic                 valid_q;
    logic                 pop;
    det_box_t             head_q;
    det_box_t             head_next;

    always_comb begin
        pop           = valid_q && rd_en;
        occ_after_pop = count - CNT_W'(pop);
        count_next    = occ_after_pop + CNT_W'(wr_en);
        rd_next       = rd_ptr + PTR_W'(pop);
        head_next     = head_q;
        // When nothing remains behind the head, the incoming word bypasses memory.
        if (wr_en && occ_after_pop == '0) begin
            head_next = wr_data;
        end else if (pop) begin
            head_next = mem[rd_next];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= 1'b0;
            head_q  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr  <= rd_next;
            count   <= count_next;
            valid_q <= (count_next != '0);
            head_q  <= head_next;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign rd_valid = valid_q;
    assign rd_data  = head_q;

endmodule

// File: rtl/detection_upscaler.sv
// Maps pyramid-level detections back to full-frame boxes through a two-stage
// multiply pipeline and a credit-controlled result FIFO.
// Optional macro DETECTION_UPSCALER_CLAMP_EN keeps the box inside the frame.
module detection_upscaler
    import vj_pkg::*;
#(
    parameter int LEVELS     = PYRAMID_LEVELS,
    parameter int COORD_W    = 10,
    parameter int FRAC       = 8,
    parameter int WINDOW     = 24,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               det_valid,
    output logic               det_ready,
    input  logic [3:0]         det_level,
    input  logic [COORD_W-1:0] det_x,
    input  logic [COORD_W-1:0] det_y,
    output logic               box_valid,
    input  logic               box_ready,
    output logic [COORD_W-1:0] box_x,
    output logic [COORD_W-1:0] box_y,
    output logic [COORD_W-1:0] box_size,
    output logic [7:0]         drop_count
);

    localparam int PROD_W    = COORD_W + 16;
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int CRED_W    = $clog2(FIFO_DEPTH) + 2;
    localparam int MAX_COORD = (1 << COORD_W) - 1;

    logic               accept;
    logic               level_bad;
    logic [15:0]        level_scale;

    logic               s1_valid;
    logic               s1_bad;
    logic [COORD_W-1:0] s1_x;
    logic [COORD_W-1:0] s1_y;
    logic [15:0]        s1_scale;

    logic               s2_valid;
    logic               s2_bad;
    det_box_t           s2_box;
    det_box_t           box_calc;

    logic               push;
    logic               pop;
    logic [CNT_W-1:0]   fifo_count;
    logic [CRED_W-1:0]  credit_next;
    det_box_t           head;

    logic [COORD_W-1:0] sx;
    logic [COORD_W-1:0] sy;
    logic [COORD_W-1:0] ssize;

    function automatic logic [COORD_W-1:0] sat(input logic [PROD_W-1:0] p);
        logic [PROD_W-1:0] s;
        s = p >> FRAC;
        if (s > PROD_W'(MAX_COORD)) return '1;
        return s[COORD_W-1:0];
    endfunction

    assign accept    = det_valid && det_ready;
    assign level_bad = int'(det_level) >= LEVELS;

    // Loop index is constant per iteration, so this reduces to a small ROM.
    always_comb begin
        level_scale = '0;
        for (int i = 0; i < LEVELS; i++) begin
            if (det_level == 4'(i)) level_scale = 16'(scale_for(i, FRAC));
        end
    end

    always_comb begin
        sx    = sat(PROD_W'(s1_x) * PROD_W'(s1_scale));
        sy    = sat(PROD_W'(s1_y) * PROD_W'(s1_scale));
        ssize = sat(PROD_W'(WINDOW) * PROD_W'(s1_scale));
        box_calc.size = ssize;
`ifdef DETECTION_UPSCALER_CLAMP_EN
        begin
            logic [COORD_W-1:0] lim_x;
            logic [COORD_W-1:0] lim_y;
            lim_x = (ssize >= COORD_W'(LAPTOP_WIDTH))  ? '0 : COORD_W'(LAPTOP_WIDTH)  - ssize;
            lim_y = (ssize >= COORD_W'(LAPTOP_HEIGHT)) ? '0 : COORD_W'(LAPTOP_HEIGHT) - ssize;
            box_calc.x = (sx > lim_x) ? lim_x : sx;
            box_calc.y = (sy > lim_y) ? lim_y : sy;
        end
`else
        box_calc.x = sx;
        box_calc.y = sy;
`endif
    end

    assign push = s2_valid && !s2_bad;
    assign pop  = box_valid && box_ready;

    // det_ready is registered from the next-cycle occupancy, which equals the
    // credit formula on registers and stays low through reset.
    assign credit_next = CRED_W'(fifo_count) + CRED_W'(push) + CRED_W'(accept)
                       + CRED_W'(s1_valid) - CRED_W'(pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            drop_count <= '0;
            det_ready  <= 1'b0;
        end else begin
            s1_valid  <= accept;
            s2_valid  <= s1_valid;
            det_ready <= (credit_next < CRED_W'(FIFO_DEPTH));
            if (s1_valid && s1_bad && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            s1_bad   <= level_bad;
            s1_x     <= det_x;
            s1_y     <= det_y;
            s1_scale <= level_scale;
        end
        s2_bad <= s1_bad;
        s2_box <= box_calc;
    end

    box_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_box_fifo (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (push),
        .wr_data  (s2_box),
        .rd_en    (box_ready),
        .rd_valid (box_valid),
        .rd_data  (head),
        .count    (fifo_count)
    );

    assign box_x    = head.x;
    assign box_y    = head.y;
    assign box_size = head.size;

endmodule

// File: tb/tb_detection_upscaler.sv
// Scoreboard bench for detection_upscaler: directed cases plus randomized
// traffic checked against an arithmetic model of the upscale rules.
module tb_detection_upscaler;
    import vj_pkg::*;

    localparam int CW  = 10;
    localparam int WIN = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          det_valid;
    logic          det_ready;
    logic [3:0]    det_level;
    logic [CW-1:0] det_x;
    logic [CW-1:0] det_y;
    logic          box_valid;
    logic          box_ready;
    logic [CW-1:0] box_x;
    logic [CW-1:0] box_y;
    logic [CW-1:0] box_size;
    logic [7:0]    drop_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int out_count = 0;
    int drops_model = 0;
    int acc_cyc = 0;
    bit rand_done = 0;
    logic [3*CW-1:0] exp_q[$];
    logic [3*CW-1:0] held;
    bit              stall_prev = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    detection_upscaler dut (
        .clock      (clk),
        .reset      (rst),
        .det_valid  (det_valid),
        .det_ready  (det_ready),
        .det_level  (det_level),
        .det_x      (det_x),
        .det_y      (det_y),
        .box_valid  (box_valid),
        .box_ready  (box_ready),
        .box_x      (box_x),
        .box_y      (box_y),
        .box_size   (box_size),
        .drop_count (drop_count)
    );

    // Reference: real-valued ratio rounded, then truncated products, saturated.
    function automatic logic [3*CW-1:0] model(input int lvl, input int x, input int y);
        int w, s, bx, by, bs;
        w  = PYRAMID_WIDTHS[lvl];
        s  = (lvl == 0) ? 256 : (2 * 256 * LAPTOP_WIDTH + w) / (2 * w);
        bx = (x * s) / 256;
        by = (y * s) / 256;
        bs = (WIN * s) / 256;
        if (bx > 1023) bx = 1023;
        if (by > 1023) by = 1023;
        if (bs > 1023) bs = 1023;
`ifdef DETECTION_UPSCALER_CLAMP_EN
        if (bx > LAPTOP_WIDTH - bs)  bx = LAPTOP_WIDTH - bs;
        if (by > LAPTOP_HEIGHT - bs) by = LAPTOP_HEIGHT - bs;
        if (bx < 0) bx = 0;
        if (by < 0) by = 0;
`endif
        return {CW'(bx), CW'(by), CW'(bs)};
    endfunction

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int lvl, input int x, input int y);
        int guard = 0;
        det_valid = 1'b1;
        det_level = 4'(lvl);
        det_x     = CW'(x);
        det_y     = CW'(y);
        while (!det_ready && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!det_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: det_ready stuck low for %0d cycles", guard);
            det_valid = 1'b0;
            return;
        end
        if (lvl < PYRAMID_LEVELS) exp_q.push_back(model(lvl, x, y));
        else if (drops_model < 255) drops_model++;
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        det_valid = 1'b0;
    endtask

    task automatic wait_box_valid(output int seen_cyc);
        int guard = 0;
        while (!box_valid && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        seen_cyc = box_valid ? cyc : -1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                total++;
                if (!box_valid || {box_x, box_y, box_size} != held) begin
                    bad++;
                    $display("FAIL stable: got v=%0b %h expected v=1 %h", box_valid,
                             {box_x, box_y, box_size}, held);
                end
            end
            if (box_valid && box_ready) begin
                total++;
                out_count++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_box: got (%0d,%0d,%0d) expected none",
                             box_x, box_y, box_size);
                end else begin
                    logic [3*CW-1:0] e;
                    e = exp_q.pop_front();
                    if ({box_x, box_y, box_size} != e) begin
                        bad++;
                        $display("FAIL box: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                                 box_x, box_y, box_size, e[3*CW-1:2*CW], e[2*CW-1:CW], e[CW-1:0]);
                    end
                end
            end
            stall_prev = box_valid && !box_ready;
            held       = {box_x, box_y, box_size};
        end
    end

    initial begin
        #500000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int seen;
        int oc;
        int acc;
        rst = 1'b1;
        det_valid = 1'b0;
        det_level = '0;
        det_x = '0;
        det_y = '0;
        box_ready = 1'b1;
        wait_cycles(3);
        check("reset_det_ready", int'(det_ready), 0);
        check("reset_box_valid", int'(box_valid), 0);
        check("reset_box_x", int'(box_x), 0);
        check("reset_box_y", int'(box_y), 0);
        check("reset_box_size", int'(box_size), 0);
        check("reset_drop_count", int'(drop_count), 0);
        rst = 1'b0;
        wait_cycles(1);
        check("ready_after_reset", int'(det_ready), 1);

        // Identity level and its latency.
        send(0, 5, 7);
        wait_box_valid(seen);
        check("identity_latency", seen, acc_cyc + 3);
        check("identity_x", int'(box_x), 5);
        check("identity_y", int'(box_y), 7);
        check("identity_size", int'(box_size), 24);

        // Level whose width is half the frame (scale 2.0).
        wait_cycles(3);
        send(3, 10, 20);
        wait_box_valid(seen);
        check("scaled_x", int'(box_x), 20);
        check("scaled_y", int'(box_y), 40);
        check("scaled_size", int'(box_size), 48);

        // Back-to-back stream must emit one box per cycle.
        wait_cycles(4);
        oc = out_count;
        for (int i = 0; i < 16; i++) begin
            send($urandom_range(0, PYRAMID_LEVELS - 1), $urandom_range(0, 1023), $urandom_range(0, 1023));
        end
        wait_cycles(3);
        check("stream_no_bubbles", out_count - oc, 16);

        // Backpressure: credits allow exactly FIFO_DEPTH accepts.
        wait_cycles(4);
        box_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            int lv, xx, yy;
            lv = $urandom_range(0, PYRAMID_LEVELS - 1);
            xx = $urandom_range(0, 1023);
            yy = $urandom_range(0, 1023);
            det_valid = 1'b1;
            det_level = 4'(lv);
            det_x = CW'(xx);
            det_y = CW'(yy);
            if (det_ready) begin
                exp_q.push_back(model(lv, xx, yy));
                acc++;
            end
            @(posedge clk);
            #1;
        end
        det_valid = 1'b0;
        check("bp_accepted", acc, 8);
        check("bp_ready_low", int'(det_ready), 0);
        check("bp_box_valid", int'(box_valid), 1);
        oc = out_count;
        box_ready = 1'b1;
        wait_cycles(12);
        check("bp_drained", out_count - oc, 8);
        check("bp_ready_back", int'(det_ready), 1);
        check("bp_queue_empty", exp_q.size(), 0);

        // Invalid level, then saturation of the drop counter.
        oc = out_count;
        send(15, 1, 1);
        wait_cycles(5);
        check("drop_one", int'(drop_count), drops_model);
        check("drop_no_output", out_count - oc, 0);
        for (int i = 0; i < 300; i++) begin
            send($urandom_range(PYRAMID_LEVELS, 15), $urandom_range(0, 1023), $urandom_range(0, 1023));
        end
        wait_cycles(5);
        check("drop_saturated", int'(drop_count), 255);
        check("drop_model", int'(drop_count), drops_model);

        // Box running past the right edge of a 320-wide frame.
        send(3, 150, 10);
        wait_box_valid(seen);
`ifdef DETECTION_UPSCALER_CLAMP_EN
        check("clamp_x", int'(box_x), 272);
`else
        check("clamp_x", int'(box_x), 300);
`endif
        check("clamp_size", int'(box_size), 48);

        // Randomized traffic with random consumer stalls.
        wait_cycles(4);
        rand_done = 0;
        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    send($urandom_range(0, 9), $urandom_range(0, 1023), $urandom_range(0, 1023));
                    if ($urandom_range(0, 3) == 0) wait_cycles($urandom_range(1, 3));
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    box_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
        join
        box_ready = 1'b1;
        wait_cycles(20);
        check("random_queue_empty", exp_q.size(), 0);
        check("random_drops", int'(drop_count), drops_model);

        // Reset with five queued and two in flight.
        box_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send($urandom_range(0, PYRAMID_LEVELS - 1), $urandom_range(0, 1023), $urandom_range(0, 1023));
        end
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        exp_q.delete();
        drops_model = 0;
        check("midreset_box_valid", int'(box_valid), 0);
        check("midreset_det_ready", int'(det_ready), 0);
        check("midreset_drop_count", int'(drop_count), 0);
        oc = out_count;
        box_ready = 1'b1;
        wait_cycles(8);
        check("midreset_no_stale", out_count - oc, 0);
        send(2, 100, 50);
        wait_cycles(6);
        check("midreset_resume", out_count - oc, 1);
        check("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/detection_upscaler.md
# detection_upscaler

Maps face-window detections reported in pyramid-level coordinates back to full-resolution `LAPTOP_WIDTH` x `LAPTOP_HEIGHT` frame coordinates and window size. It is the inverse of the pyramid downscaler's nearest-neighbour mapping. The block sits between the per-level classifier outputs and the bounding-box drawing/reporting logic. It has a 2-stage multiply pipeline, a result FIFO and valid/ready handshakes on both sides.

## Interface
- `LEVELS`, default `PYRAMID_LEVELS`: number of pyramid levels.
- `COORD_W`, default 10: coordinate and size width.
- `FRAC`, default 8: fractional bits of scale factors.
- `WINDOW`, default 24: detector window edge in pixels.
- `FIFO_DEPTH`, default 8: result FIFO entries; must be a power of 2 and ≥ 2.
- `clock`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `det_valid`  in  1: a detection is offered.
- `det_ready`  out  1: the block can accept a detection.
- `det_level`  in  4: pyramid index of the detection.
- `det_x`, `det_y`  in  COORD_W: window top-left corner in level coordinates.
- `box_valid`  out  1: the FIFO head is valid.
- `box_ready`  in  1: the consumer takes the head.
- `box_x`, `box_y`  out  COORD_W: top-left corner in full-frame coordinates.
- `box_size`  out  COORD_W: window edge in full-frame pixels.
- `drop_count`  out  8: saturating count of rejected detections.

## Operation
- **Accept:** a detection is accepted when `det_valid && det_ready`.
- **Stage 1:** registers the inputs and looks up `SCALE_Q[det_level]`.
  - If `det_level >= LEVELS`, the entry is marked invalid.
  - An invalid entry increments `drop_count`, which saturates at 255, and produces no output.
- **Stage 2:** computes the products, COORD_W+16 bits wide, then truncates with `>> FRAC`.
  - `box_x = (x*S)>>FRAC`
  - `box_y = (y*S)>>FRAC`
  - `box_size = (WINDOW*S)>>FRAC`
  - Each result saturates to `2^COORD_W-1`.
- **FIFO write:** valid stage-2 results are written to the FIFO in order.
- **FIFO read:** occurs on `box_valid && box_ready`. `box_*` are driven from the FIFO head register.
- **Credit flow control:** `det_ready = (fifo_count + s1_valid + s2_valid) < FIFO_DEPTH`, computed from registers only.
  - The FIFO can never overflow.
  - Dropped entries still consume a credit while in flight.
- **Simultaneous read and write:** allowed, including when the FIFO is full or empty. The count is unchanged and ordering is preserved.
- **Pointers:** wrap modulo `FIFO_DEPTH`.

## Timing
- **Reset values:** every output is 0 (`det_ready` is 0 during reset). Pipeline valids, FIFO pointers and count, and `drop_count` are also cleared.
  - `det_ready` rises in the first cycle after reset deasserts.
- **Reset mid-operation:** flushes all in-flight and queued entries. Nothing is emitted afterwards.
- **Latency:** a detection accepted in cycle c appears with `box_valid=1` in cycle c+3 if the FIFO was empty. This assumes no earlier queued entries.
- **Throughput:** one detection per cycle while `box_ready` stays high.
- **Output stability:** `box_*` stay stable while `box_valid && !box_ready`.

## Configuration
- Macro: `DETECTION_UPSCALER_CLAMP_EN`.
- **Defined:** after scaling, the box is clamped to stay inside the frame.
  - `box_x = min(box_x, LAPTOP_WIDTH - box_size)`
  - `box_y = min(box_y, LAPTOP_HEIGHT - box_size)`
  - Floor at 0.
  - The clamp is an extra combinational step in stage 2; latency is unchanged.
- **Undefined:** raw saturated values are emitted. The box may extend past the frame edge.

## Structure
- Shared package `vj_pkg` holds:
  - `SCALE_Q[LEVELS]`, computed as `round(2^FRAC * LAPTOP_WIDTH / PYRAMID_WIDTHS[level])`, with `SCALE_Q[0] = 2^FRAC`.
  - A `det_box_t` struct holding x, y and size.
- One sub-module: `box_fifo`, a synchronous FIFO of `det_box_t` with a registered count and head.

## Test plan
- **Identity level:** level 0, x=5, y=7, `box_ready=1` → box (5, 7, 24) with `box_valid` in cycle c+3.
- **Scaled level:** level with S=512 and FRAC=8, x=10, y=20 → box (20, 40, 48). Also stream 16 back-to-back detections → in-order outputs with no bubbles.
- **Backpressure:** `box_ready=0`, `det_valid` held → exactly 8 accepted, then `det_ready=0`. Raise `box_ready` → 8 outputs in order, then `det_ready` returns.
- **Bad level:** level 15 → no output and `drop_count=1`. Then 300 bad levels → `drop_count` holds at 255.
- **Clamp:** `LAPTOP_WIDTH=320`, S=512, x=150 → `box_x=272` and size 48 with the macro defined; `box_x=300` without it.
- **Reset mid-operation:** 5 queued and 2 in flight, then reset for 1 cycle → `box_valid=0` and no stale output; the next detection emits normally.
